systolic_feeder: RTL and testbench

Upstream stage of the N×N int8 systolic array. It reads one activation vector and one weight vector per reduction step from the operand buffers. Activations get the 9-bit input offset; weights pass through unmodified. Both streams are diagonally skewed onto the array's left edge (9-bit lanes) and top edge (8-bit lanes). The block also sequences the PE accumulator clear and reports completion once every PE accumulator holds its final sum.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_delay_line.sv | 41 ++++
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array front end.
package systolic_pkg;

    localparam int ACT_W     = 8;
    localparam int LEFT_W    = 9;
    localparam int ACC_W     = 32;
    localparam int DEFAULT_N = 4;
    // Upper bound on lanes accepted by act_lane; callers zero-extend into this width.
    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [ACT_W-1:0] act_lane(input logic [ACT_W*MAX_LANES-1:0] vec,
                                                  input int unsigned idx);
        return vec[ACT_W*idx +: ACT_W];
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; depth 0 is a plain wire.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_s;
            assign unused_clk_s = clk ^ reset;
            assign out_valid    = in_valid;
            assign out_data     = in_data;
        end else begin : g_shift
            logic [W:0] stage_r [DEPTH];

            // Shift {valid, data} one stage per cycle
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        stage_r[s] <= {(W+1){1'b0}};
                    end
                end else begin
                    stage_r[0] <= {in_valid, in_data};
                    for (int s = 1; s < DEPTH; s++) begin
                        stage_r[s] <= stage_r[s-1];
                    end
                end
            end

            assign {out_valid, out_data} = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Reads operand vectors, applies the activation offset and skews both streams
// diagonally onto the systolic array edges; sequences accumulator clear and done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int K_MAX = 256,
    parameter int AW    = $clog2(K_MAX),
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  logic [LEFT_W-1:0]   input_offset,
    output logic [AW-1:0]       a_addr,
    output logic                a_ren,
    input  logic [ACT_W*N-1:0]  a_rdata,
    output logic [AW-1:0]       b_addr,
    output logic                b_ren,
    input  logic [ACT_W*N-1:0]  b_rdata,
    output logic [LEFT_W*N-1:0] left_data,
    output logic [ACT_W*N-1:0]  top_data,
    output logic                pe_rst,
    output logic                busy,
    output logic                done
);

    // FEED counter must reach K_MAX + 2N - 2.
    localparam int CW = $clog2(K_MAX + 2*N);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [KW-1:0]          k_r;
    logic [LEFT_W-1:0]      offset_r;
    logic [CW-1:0]          f_r;
    logic [AW-1:0]          addr_hold_r;
    logic                   rd_valid_r;
    logic [KW-1:0]          k_clamped_s;
    logic                   feed_last_s;
    logic                   ren_s;
    logic [AW-1:0]          addr_s;
    logic [ACT_W*MAX_LANES-1:0] a_ext_s;
    logic [ACT_W*MAX_LANES-1:0] b_ext_s;

    assign k_clamped_s = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign feed_last_s = (f_r == (CW'(k_r) + CW'(2*N - 2)));
    assign ren_s       = (state_r == ST_FEED) && (f_r < CW'(k_r));
    assign addr_s      = ren_s ? AW'(f_r) : addr_hold_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (k_r != {KW{1'b0}}) begin
                    state_next_s = ST_FEED;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_FEED: begin
                if (feed_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FEED;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the registered state
    always_comb begin
        pe_rst = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state_r)
            ST_IDLE:  busy   = 1'b0;
            ST_CLEAR: pe_rst = 1'b1;
            ST_FEED:  busy   = 1'b1;
            ST_DONE:  done   = 1'b1;
            default:  busy   = 1'b0;
        endcase
    end

    // Tile parameters, step counter, held read address and read-data valid
    always_ff @(posedge clk) begin
        if (reset) begin
            k_r         <= {KW{1'b0}};
            offset_r    <= {LEFT_W{1'b0}};
            f_r         <= {CW{1'b0}};
            addr_hold_r <= {AW{1'b0}};
            rd_valid_r  <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                k_r      <= k_clamped_s;
                offset_r <= input_offset;
            end
            if (state_r == ST_FEED) begin
                f_r <= f_r + CW'(1);
            end else begin
                f_r <= {CW{1'b0}};
            end
            addr_hold_r <= addr_s;
            rd_valid_r  <= ren_s;
        end
    end

    assign a_addr = addr_s;
    assign b_addr = addr_s;
    assign a_ren  = ren_s;
    assign b_ren  = ren_s;

    // Zero-extend the read vectors into the lane-extraction width
    always_comb begin
        a_ext_s = {(ACT_W*MAX_LANES){1'b0}};
        b_ext_s = {(ACT_W*MAX_LANES){1'b0}};
        a_ext_s[ACT_W*N-1:0] = a_rdata;
        b_ext_s[ACT_W*N-1:0] = b_rdata;
    end

    // Lane i is delayed by i stages; edge values are forced to zero whenever the lane's valid bit is low
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [ACT_W-1:0]  a_lane_s;
        logic [ACT_W-1:0]  b_lane_s;
        logic [LEFT_W-1:0] left_in_s;
        logic [LEFT_W-1:0] left_out_s;
        logic [ACT_W-1:0]  top_out_s;
        logic              left_vld_s;
        logic              top_vld_s;

        assign a_lane_s  = act_lane(a_ext_s, i);
        assign b_lane_s  = act_lane(b_ext_s, i);
        assign left_in_s = {a_lane_s[ACT_W-1], a_lane_s} + offset_r;

        skew_delay_line #(.DEPTH(i), .W(LEFT_W)) u_left (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (rd_valid_r),
            .in_data   (left_in_s),
            .out_valid (left_vld_s),
            .out_data  (left_out_s)
        );

        skew_delay_line #(.DEPTH(i), .W(ACT_W)) u_top (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (rd_valid_r),
            .in_data   (b_lane_s),
            .out_valid (top_vld_s),
            .out_data  (top_out_s)
        );

        assign left_data[LEFT_W*i +: LEFT_W] = left_vld_s ? left_out_s : {LEFT_W{1'b0}};
        assign top_data[ACT_W*i +: ACT_W]    = top_vld_s  ? top_out_s  : {ACT_W{1'b0}};
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized tiles against a reference of the skew formula plus
// a behavioural PE array whose accumulators are compared with the matrix product.
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int AW    = 8;
    localparam int KW    = 9;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [KW-1:0]  k_len;
    logic [8:0]     input_offset;
    logic [AW-1:0]  a_addr, b_addr;
    logic           a_ren, b_ren;
    logic [8*N-1:0] a_rdata, b_rdata;
    logic [9*N-1:0] left_data;
    logic [8*N-1:0] top_data;
    logic           pe_rst, busy, done;

    int total = 0;
    int bad   = 0;

    logic [8*N-1:0] a_mem [K_MAX];
    logic [8*N-1:0] b_mem [K_MAX];
    int acc  [N][N];
    int hreg [N][N];
    int vreg [N][N];

    systolic_feeder #(.N(N), .K_MAX(K_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .input_offset (input_offset),
        .a_addr       (a_addr),
        .a_ren        (a_ren),
        .a_rdata      (a_rdata),
        .b_addr       (b_addr),
        .b_ren        (b_ren),
        .b_rdata      (b_rdata),
        .left_data    (left_data),
        .top_data     (top_data),
        .pe_rst       (pe_rst),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Operand buffers with one-cycle read latency
    always @(posedge clk) begin
        if (a_ren) a_rdata <= a_mem[a_addr];
        if (b_ren) b_rdata <= b_mem[b_addr];
    end

    function automatic int lin_of(int i, int j);
        if (j == 0) return int'($signed(left_data[9*i +: 9]));
        return hreg[i][j-1];
    endfunction

    function automatic int tin_of(int i, int j);
        if (i == 0) return int'($signed(top_data[8*j +: 8]));
        return vreg[i-1][j];
    endfunction

    // Output-stationary PE array driven by the feeder edges
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (reset) begin
                    acc[i][j]  <= 0;
                    hreg[i][j] <= 0;
                    vreg[i][j] <= 0;
                end else begin
                    hreg[i][j] <= lin_of(i, j);
                    vreg[i][j] <= tin_of(i, j);
                    acc[i][j]  <= pe_rst ? 0 : acc[i][j] + lin_of(i, j) * tin_of(i, j);
                end
            end
        end
    end

    // Offset-adjusted activation as a signed value wrapped to 9 bits
    function automatic int lane_val(input logic [7:0] a, input logic [8:0] off);
        int v;
        v = int'($signed(a)) + int'($signed(off));
        return ((v + 256 + 512) % 512) - 256;
    endfunction

    function automatic logic [9*N-1:0] exp_left(int f, int k, logic [8:0] off);
        logic [9*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = f - 1 - i;
            if (idx >= 0 && idx < k) r[9*i +: 9] = 9'(lane_val(a_mem[idx][8*i +: 8], off));
        end
        return r;
    endfunction

    function automatic logic [8*N-1:0] exp_top(int f, int k);
        logic [8*N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = f - 1 - j;
            if (idx >= 0 && idx < k) r[8*j +: 8] = b_mem[idx][8*j +: 8];
        end
        return r;
    endfunction

    function automatic int exp_acc(int i, int j, int k, logic [8:0] off);
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
            s += lane_val(a_mem[kk][8*i +: 8], off) * int'($signed(b_mem[kk][8*j +: 8]));
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rand();
        for (int kk = 0; kk < K_MAX; kk++) begin
            a_mem[kk] = $urandom;
            b_mem[kk] = $urandom;
        end
    endtask

    task automatic run_tile(input string name, input int k_in, input logic [8:0] off,
                            input bit hold_start, input bit poke);
        int k;
        int rens;
        int nfeed;
        k     = (k_in > K_MAX) ? K_MAX : k_in;
        rens  = 0;
        nfeed = (k > 0) ? k + 2*N - 1 : 0;
        @(negedge clk);
        start        = 1'b1;
        k_len        = KW'(k_in);
        input_offset = off;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        k_len        = 9'd5;
        input_offset = ~off;
        chk({name, " clear ctl"}, {61'd0, pe_rst, busy, done}, 64'b110);
        chk({name, " clear ren"}, {62'd0, a_ren, b_ren}, 64'd0);
        chk({name, " clear edge"}, {left_data, top_data}, 64'd0);
        for (int f = 0; f < nfeed; f++) begin
            @(posedge clk); #1;
            if (poke) start = (f == 2);
            chk({name, " feed ctl"}, {61'd0, pe_rst, busy, done}, 64'b010);
            chk({name, " feed ren"}, {62'd0, a_ren, b_ren}, (f < k) ? 64'b11 : 64'b00);
            if (f < k) rens++;
            chk({name, " feed addr"}, {48'd0, a_addr, b_addr},
                {48'd0, AW'((f < k) ? f : k - 1), AW'((f < k) ? f : k - 1)});
            chk({name, " left"}, 64'(left_data), 64'(exp_left(f, k, off)));
            chk({name, " top"}, 64'(top_data), 64'(exp_top(f, k)));
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " done ctl"}, {61'd0, pe_rst, busy, done}, 64'b011);
        chk({name, " done edge"}, {left_data, top_data}, 64'd0);
        chk({name, " ren count"}, 64'(rens), 64'(k));
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk({name, " acc"}, 64'(acc[i][j]), 64'(exp_acc(i, j, k, off)));
            end
        end
        @(posedge clk); #1;
        chk({name, " idle ctl"}, {61'd0, pe_rst, busy, done}, 64'd0);
        chk({name, " idle edge"}, {left_data, top_data}, 64'd0);
        if (hold_start) begin
            @(posedge clk); #1;
            chk({name, " single tile"}, {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        k_len        = '0;
        input_offset = '0;
        a_rdata      = '0;
        b_rdata      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctl", {61'd0, pe_rst, busy, done}, 64'd0);
        chk("reset ren", {46'd0, a_ren, b_ren, a_addr, b_addr}, 64'd0);
        chk("reset edge", {left_data, top_data}, 64'd0);
        reset = 1'b0;

        // Single element: (-128 + 128) * 3
        load_rand();
        a_mem[0] = 32'h80808080;
        b_mem[0] = 32'h03030303;
        run_tile("single", 1, 9'd128, 1'b0, 1'b0);

        // Identity activations reproduce the weight matrix
        for (int kk = 0; kk < 4; kk++) begin
            a_mem[kk] = 32'(1) << (8 * kk);
            for (int j = 0; j < N; j++) b_mem[kk][8*j +: 8] = 8'(4 * kk + j + 1);
        end
        run_tile("identity", 4, 9'd0, 1'b0, 1'b0);

        // Offset wrap: 100 + 200 -> 9'h12C, -128 + -256 -> 9'h080
        for (int kk = 0; kk < 3; kk++) a_mem[kk] = 32'h64646464;
        run_tile("wrap pos", 3, 9'd200, 1'b0, 1'b0);
        for (int kk = 0; kk < 3; kk++) a_mem[kk] = 32'h80808080;
        run_tile("wrap neg", 3, 9'h100, 1'b0, 1'b0);

        run_tile("k zero", 0, 9'($urandom), 1'b0, 1'b0);

        load_rand();
        run_tile("hold start", 5, 9'($urandom), 1'b1, 1'b0);
        load_rand();
        run_tile("poke start", 6, 9'($urandom), 1'b0, 1'b1);
        load_rand();
        run_tile("b2b first", int'($urandom_range(1, 20)), 9'($urandom), 1'b0, 1'b0);
        load_rand();
        run_tile("b2b second", int'($urandom_range(1, 20)), 9'($urandom), 1'b0, 1'b0);

        // Reset during FEED step 3 of a K=8 tile
        load_rand();
        @(negedge clk);
        start        = 1'b1;
        k_len        = 9'd8;
        input_offset = 9'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int f = 0; f <= 3; f++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset ctl", {61'd0, pe_rst, busy, done}, 64'd0);
        chk("midreset ren", {46'd0, a_ren, b_ren, a_addr, b_addr}, 64'd0);
        chk("midreset edge", {left_data, top_data}, 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk("midreset quiet", {62'd0, busy, done}, 64'd0);
        end
        run_tile("after reset", 8, 9'($urandom), 1'b0, 1'b0);

        load_rand();
        run_tile("clamp", 300, 9'($urandom), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
